// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the enqueue packet bus, the dequeue lane bus and the
// occupancy status of the fetch queue.
//
// Handshake semantics:
//   Enqueue: a packet transfers on a rising edge when enq_valid && enq_ready
//   && !flush. enq_ready depends only on registered occupancy, never on
//   enq_valid. Dequeue: lane i transfers when deq_valid[i] && deq_ready[i]
//   and every lower lane also transfers. deq_valid never depends on
//   deq_ready.
//
// Modports:
//   slave  - the queue (consumes enq_*, flush, backend_stall, deq_ready)
//   master - the surrounding fetch/decode environment
interface fetch_queue_if #(
  parameter int FETCH_WIDTH = 4,
  parameter int DEQ_WIDTH   = 2,
  parameter int DEPTH       = 16,
  parameter int PC_WIDTH    = 64,
  parameter int INST_WIDTH  = 32
);
  logic                              enq_valid;
  logic                              enq_ready;
  logic [PC_WIDTH-1:0]               enq_pc;
  logic [FETCH_WIDTH*INST_WIDTH-1:0] enq_inst;
  logic [FETCH_WIDTH-1:0]            enq_slot_valid;
  logic [FETCH_WIDTH-1:0]            enq_predtaken;
  logic [FETCH_WIDTH*INST_WIDTH-1:0] enq_predtarget;
  logic                              flush;
  logic                              backend_stall;
  logic [DEQ_WIDTH-1:0]              deq_valid;
  logic [DEQ_WIDTH-1:0]              deq_ready;
  logic [DEQ_WIDTH*INST_WIDTH-1:0]   deq_inst;
  logic [DEQ_WIDTH*PC_WIDTH-1:0]     deq_pc;
  logic [DEQ_WIDTH-1:0]              deq_predtaken;
  logic [DEQ_WIDTH*INST_WIDTH-1:0]   deq_predtarget;
  logic [$clog2(DEPTH):0]            count;
  logic                              empty;

  modport slave (
    input  enq_valid, enq_pc, enq_inst, enq_slot_valid, enq_predtaken,
           enq_predtarget, flush, backend_stall, deq_ready,
    output enq_ready, deq_valid, deq_inst, deq_pc, deq_predtaken,
           deq_predtarget, count, empty
  );

  modport master (
    output enq_valid, enq_pc, enq_inst, enq_slot_valid, enq_predtaken,
           enq_predtarget, flush, backend_stall, deq_ready,
    input  enq_ready, deq_valid, deq_inst, deq_pc, deq_predtaken,
           deq_predtarget, count, empty
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch packet assembly and
// decode. Accepts one FETCH_WIDTH-slot packet per cycle, truncates it after
// the first predicted-taken slot, compacts the surviving slots and issues up
// to DEQ_WIDTH entries per cycle in program order.
//
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-high reset
//   q     - fetch_queue_if.slave: enqueue packet, dequeue lanes, flush,
//           backend_stall, count/empty status
module fetch_queue #(
  parameter int FETCH_WIDTH = 4,
  parameter int DEQ_WIDTH   = 2,
  parameter int DEPTH       = 16,
  parameter int PC_WIDTH    = 64,
  parameter int INST_WIDTH  = 32
) (
  input logic          clock,
  input logic          reset,
  fetch_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [INST_WIDTH-1:0] mem_inst [DEPTH];
  logic [PC_WIDTH-1:0]   mem_pc   [DEPTH];
  logic                  mem_pt   [DEPTH];
  logic [INST_WIDTH-1:0] mem_tgt  [DEPTH];

  logic [FETCH_WIDTH-1:0] eff_mask;
  logic                   cut;
  logic [CW-1:0]          slot_off [FETCH_WIDTH];
  logic [CW-1:0]          n_enq;
  logic [CW-1:0]          n_enq_eff;
  logic [CW-1:0]          n_pop;
  logic                   pop_run;
  logic                   enq_fire;

  // Credit is based on current occupancy only: a pop in the same cycle does
  // not open room for a packet.
  assign q.enq_ready = (count <= CW'(DEPTH - FETCH_WIDTH));
  assign enq_fire    = q.enq_valid && q.enq_ready && !q.flush;
  assign q.count     = count;
  assign q.empty     = (count == '0);

  // Keep slots up to and including the first predicted-taken one, then give
  // each kept slot its compacted write offset from tail.
  always_comb begin
    eff_mask = '0;
    cut      = 1'b0;
    n_enq    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_off[i] = n_enq;
      if (!cut) begin
        eff_mask[i] = q.enq_slot_valid[i];
        if (q.enq_slot_valid[i] && q.enq_predtaken[i]) cut = 1'b1;
      end
      n_enq = n_enq + CW'(eff_mask[i]);
    end
    n_enq_eff = enq_fire ? n_enq : '0;
  end

  // Lane i shows entry head+i; pops stop at the first lane not consumed.
  always_comb begin
    q.deq_valid      = '0;
    q.deq_inst       = '0;
    q.deq_pc         = '0;
    q.deq_predtaken  = '0;
    q.deq_predtarget = '0;
    n_pop            = '0;
    pop_run          = 1'b1;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      q.deq_valid[i] = (count > CW'(i)) && !q.backend_stall && !q.flush;
      q.deq_inst[i*INST_WIDTH +: INST_WIDTH]       = mem_inst[head + PW'(i)];
      q.deq_pc[i*PC_WIDTH +: PC_WIDTH]             = mem_pc[head + PW'(i)];
      q.deq_predtaken[i]                           = mem_pt[head + PW'(i)];
      q.deq_predtarget[i*INST_WIDTH +: INST_WIDTH] = mem_tgt[head + PW'(i)];
      if (pop_run && q.deq_valid[i] && q.deq_ready[i]) n_pop = n_pop + 1'b1;
      else pop_run = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_pop);
      tail  <= tail + PW'(n_enq_eff);
      count <= count + n_enq_eff - n_pop;
    end
  end

  // Storage carries no reset; pointers and count define what is live.
  always_ff @(posedge clock) begin
    if (enq_fire && !reset) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (eff_mask[i]) begin
          mem_inst[tail + PW'(slot_off[i])] <= q.enq_inst[i*INST_WIDTH +: INST_WIDTH];
          mem_pc[tail + PW'(slot_off[i])]   <= q.enq_pc + PC_WIDTH'(4 * i);
          mem_pt[tail + PW'(slot_off[i])]   <= q.enq_predtaken[i];
          mem_tgt[tail + PW'(slot_off[i])]  <= q.enq_predtarget[i*INST_WIDTH +: INST_WIDTH];
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int FW = 4;
  localparam int DW = 2;
  localparam int DEPTH = 16;
  localparam int PCW = 64;
  localparam int IW = 32;
  localparam int EW = PCW + IW + 1 + IW;

  logic clock;
  logic reset;

  fetch_queue_if #(.FETCH_WIDTH(FW), .DEQ_WIDTH(DW), .DEPTH(DEPTH),
                   .PC_WIDTH(PCW), .INST_WIDTH(IW)) q();

  fetch_queue #(.FETCH_WIDTH(FW), .DEQ_WIDTH(DW), .DEPTH(DEPTH),
                .PC_WIDTH(PCW), .INST_WIDTH(IW)) dut (
    .clock(clock),
    .reset(reset),
    .q(q)
  );

  int tests;
  int fails;
  logic [EW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- helpers ----------------
  function automatic logic [IW-1:0] inst_of(input logic [PCW-1:0] pc);
    return pc[IW-1:0] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [IW-1:0] tgt_of(input logic [PCW-1:0] pc);
    return pc[IW-1:0] + 32'h40;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives one packet for one cycle. Expected entries are pushed only when the
  // packet is accepted and not flushed; a flush wipes expectations.
  task automatic send(input logic [PCW-1:0] pc, input logic [FW-1:0] sv,
                      input logic [FW-1:0] pt, input logic do_flush);
    int  waited;
    logic stop;
    waited = 0;
    while (!q.enq_ready && waited < 100) begin
      step(1);
      waited++;
    end
    if (!q.enq_ready) begin
      tests++;
      fails++;
      $display("FAIL enq_ready_timeout: got 0 expected 1");
    end
    q.enq_valid      = 1'b1;
    q.enq_pc         = pc;
    q.enq_slot_valid = sv;
    q.enq_predtaken  = pt;
    q.flush          = do_flush;
    for (int i = 0; i < FW; i++) begin
      q.enq_inst[i*IW +: IW]       = inst_of(pc + 64'(4 * i));
      q.enq_predtarget[i*IW +: IW] = tgt_of(pc + 64'(4 * i));
    end
    if (do_flush) begin
      exp_q.delete();
    end else if (q.enq_ready) begin
      stop = 1'b0;
      for (int i = 0; i < FW; i++) begin
        if (!stop && sv[i]) begin
          exp_q.push_back({pc + 64'(4 * i), inst_of(pc + 64'(4 * i)), pt[i],
                           tgt_of(pc + 64'(4 * i))});
          if (pt[i]) stop = 1'b1;
        end
      end
    end
    step(1);
    q.enq_valid = 1'b0;
    q.flush     = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic run;
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    run = 1'b1;
    if (!reset) begin
      for (int i = 0; i < DW; i++) begin
        if (run && q.deq_valid[i] && q.deq_ready[i]) begin
          got = {q.deq_pc[i*PCW +: PCW], q.deq_inst[i*IW +: IW],
                 q.deq_predtaken[i], q.deq_predtarget[i*IW +: IW]};
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL deq_unexpected lane%0d: got pc 0x%0h expected none", i,
                     q.deq_pc[i*PCW +: PCW]);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              fails++;
              $display("FAIL deq_entry lane%0d: got pc 0x%0h inst 0x%0h pt %0b tgt 0x%0h expected pc 0x%0h inst 0x%0h pt %0b tgt 0x%0h",
                       i, got[EW-1 -: PCW], got[IW+1+IW-1 -: IW], got[IW], got[IW-1:0],
                       exp[EW-1 -: PCW], exp[IW+1+IW-1 -: IW], exp[IW], exp[IW-1:0]);
            end
          end
        end else begin
          run = 1'b0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    q.enq_valid = 1'b0;
    q.enq_pc = '0;
    q.enq_inst = '0;
    q.enq_slot_valid = '0;
    q.enq_predtaken = '0;
    q.enq_predtarget = '0;
    q.flush = 1'b0;
    q.backend_stall = 1'b0;
    q.deq_ready = '0;
    step(3);
    check("reset_count", 64'(q.count), 64'd0);
    check("reset_empty", 64'(q.empty), 64'd1);
    check("reset_enq_ready", 64'(q.enq_ready), 64'd1);
    check("reset_deq_valid", 64'(q.deq_valid), 64'd0);
    reset = 1'b0;
    step(1);

    // Basic: four slots, two lanes per cycle
    q.deq_ready = 2'b11;
    send(64'h1000, 4'b1111, 4'b0000, 1'b0);
    check("basic_c1_valid", 64'(q.deq_valid), 64'h3);
    check("basic_c1_pc0", q.deq_pc[0 +: PCW], 64'h1000);
    check("basic_c1_pc1", q.deq_pc[PCW +: PCW], 64'h1004);
    step(1);
    check("basic_c2_pc0", q.deq_pc[0 +: PCW], 64'h1008);
    check("basic_c2_pc1", q.deq_pc[PCW +: PCW], 64'h100C);
    step(1);
    check("basic_empty", 64'(q.empty), 64'd1);
    check("basic_count", 64'(q.count), 64'd0);

    // Compaction and truncation
    q.deq_ready = 2'b00;
    send(64'h1000, 4'b1101, 4'b0100, 1'b0);
    check("compact_count", 64'(q.count), 64'd2);
    check("compact_pc1", q.deq_pc[PCW +: PCW], 64'h1008);
    check("compact_pt", 64'(q.deq_predtaken), 64'h2);
    q.deq_ready = 2'b11;
    step(1);
    check("compact_drained", 64'(q.count), 64'd0);

    // Full and backpressure
    q.deq_ready = 2'b00;
    for (int k = 0; k < 4; k++) send(64'h2000 + 64'(16 * k), 4'b1111, 4'b0000, 1'b0);
    check("full_count", 64'(q.count), 64'd16);
    check("full_enq_ready", 64'(q.enq_ready), 64'd0);
    q.deq_ready = 2'b01;
    step(3);
    check("bp_count13", 64'(q.count), 64'd13);
    check("bp_ready_at13", 64'(q.enq_ready), 64'd0);
    step(1);
    check("bp_ready_at12", 64'(q.enq_ready), 64'd1);
    q.deq_ready = 2'b11;
    step(6);
    check("bp_drained", 64'(q.count), 64'd0);

    // Partial lane ready
    q.deq_ready = 2'b00;
    send(64'h3000, 4'b0111, 4'b0000, 1'b0);
    check("partial_count3", 64'(q.count), 64'd3);
    q.deq_ready = 2'b10;
    step(1);
    check("partial_hi_only", 64'(q.count), 64'd3);
    q.deq_ready = 2'b01;
    step(1);
    check("partial_lo_only", 64'(q.count), 64'd2);
    q.deq_ready = 2'b11;
    step(1);
    check("partial_drained", 64'(q.count), 64'd0);

    // Stall blocks dequeue but not enqueue
    q.backend_stall = 1'b1;
    send(64'h3100, 4'b0001, 4'b0000, 1'b0);
    check("stall_deq_valid", 64'(q.deq_valid), 64'd0);
    check("stall_count", 64'(q.count), 64'd1);
    q.backend_stall = 1'b0;
    step(1);
    check("stall_drained", 64'(q.count), 64'd0);

    // Wrap: head = tail = 10 here; advance to 14, then straddle the end
    send(64'h4000, 4'b1111, 4'b0000, 1'b0);
    step(2);
    check("wrap_pre_empty", 64'(q.empty), 64'd1);
    q.deq_ready = 2'b00;
    send(64'h5000, 4'b1111, 4'b0000, 1'b0);
    check("wrap_count", 64'(q.count), 64'd4);
    check("wrap_pc1", q.deq_pc[PCW +: PCW], 64'h5004);
    q.deq_ready = 2'b11;
    step(1);
    check("wrap_pc0_after", q.deq_pc[0 +: PCW], 64'h5008);
    check("wrap_pc1_after", q.deq_pc[PCW +: PCW], 64'h500C);
    step(1);
    check("wrap_drained", 64'(q.count), 64'd0);

    // Flush with concurrent enqueue and ready lanes
    q.deq_ready = 2'b00;
    send(64'h6000, 4'b1111, 4'b0000, 1'b0);
    send(64'h6010, 4'b1111, 4'b0000, 1'b0);
    send(64'h6020, 4'b0001, 4'b0000, 1'b0);
    check("flush_pre_count", 64'(q.count), 64'd9);
    q.deq_ready = 2'b11;
    q.flush = 1'b1;
    #1;
    check("flush_deq_valid", 64'(q.deq_valid), 64'd0);
    q.flush = 1'b0;
    send(64'h7000, 4'b1111, 4'b0000, 1'b1);
    check("flush_count", 64'(q.count), 64'd0);
    check("flush_empty", 64'(q.empty), 64'd1);
    send(64'h8000, 4'b0011, 4'b0000, 1'b0);
    check("post_flush_pc0", q.deq_pc[0 +: PCW], 64'h8000);
    step(2);
    check("post_flush_drained", 64'(q.count), 64'd0);

    check("scoreboard_left", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
